// File: rtl/fetch_issue.sv
// fetch_issue: program-counter owner and instruction-memory request issuer.
// Issues one read per cycle while running, tags accepted requests with their
// PC, and applies halt/start, redirect, stall and memory back-pressure.
module fetch_issue #(
  parameter int                        ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0]   RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic                    halt,
  input  logic                    stall,
  input  logic                    branch_valid,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    trap_valid,
  input  logic [ADDRESS_BITS-1:0] trap_target,
  input  logic                    i_mem_ready,
  output logic                    i_mem_read,
  output logic [ADDRESS_BITS-1:0] i_mem_read_address,
  output logic [ADDRESS_BITS-1:0] issue_PC,
  output logic                    issue_valid
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);
  localparam logic [ADDRESS_BITS-1:0] PC_STEP    = ADDRESS_BITS'(4);

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [ADDRESS_BITS-1:0] issue_pc_q, issue_pc_d;
  logic                    issue_valid_q, issue_valid_d;

  logic                    redirect;
  logic [ADDRESS_BITS-1:0] redirect_pc;
  logic                    accept;

  assign redirect    = trap_valid | branch_valid;
  assign redirect_pc = (trap_valid ? trap_target : branch_target) & ALIGN_MASK;
  assign accept      = i_mem_ready & ~stall & ~redirect;

  // State, PC and issue tag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      issue_pc_q    <= RESET_PC;
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issue_pc_q    <= issue_pc_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  // Next state: halt beats redirect beats accept beats stall beats bubble.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    issue_pc_d    = issue_pc_q;
    issue_valid_d = issue_valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          pc_d          = program_address & ALIGN_MASK;
          issue_valid_d = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          state_d       = IDLE;
          issue_valid_d = 1'b0;
        end else if (redirect) begin
          // The request currently in flight belongs to the old path.
          pc_d          = redirect_pc;
          issue_valid_d = 1'b0;
        end else if (accept) begin
          issue_pc_d    = pc_q;
          issue_valid_d = 1'b1;
          pc_d          = pc_q + PC_STEP;
        end else if (!stall) begin
          // Memory refused the request: nothing new for fetch receive.
          issue_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_mem_read         = (state_q == RUN);
  assign i_mem_read_address = pc_q;
  assign issue_PC           = issue_pc_q;
  assign issue_valid        = issue_valid_q;

endmodule

// File: doc/fetch_issue.md
Name: fetch_issue

Overview:
- Issue side of the instruction-fetch interface; owns the program counter.
- Drives instruction-memory read requests and tags each accepted request with its PC for the downstream fetch-receive stage.
- Applies redirects (trap, branch/jump), pipeline stall, memory back-pressure and halt/start sequencing.
- Sits between the control/writeback redirect logic and instruction memory, one stage ahead of fetch receive.

Parameters:
- ADDRESS_BITS, 32, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  in IDLE, load program_address and begin fetching.
- program_address  input  ADDRESS_BITS  start PC used with start.
- halt  input  1  in RUN, stop issuing and return to IDLE.
- stall  input  1  downstream pipeline frozen.
- branch_valid  input  1  redirect to branch_target.
- branch_target  input  ADDRESS_BITS  branch/jump destination.
- trap_valid  input  1  redirect to trap_target; overrides branch.
- trap_target  input  ADDRESS_BITS  trap handler address.
- i_mem_ready  input  1  memory accepts the current request this cycle.
- i_mem_read  output  1  read request valid.
- i_mem_read_address  output  ADDRESS_BITS  equals current PC.
- issue_PC  output  ADDRESS_BITS  PC of the last accepted request (registered).
- issue_valid  output  1  issue_PC/returned data is a real, non-squashed fetch.

Behaviour:
- States: IDLE, RUN. Reset (reset=0, asynchronous) forces IDLE, PC=RESET_PC, issue_PC=RESET_PC, issue_valid=0; i_mem_read=0, i_mem_read_address=RESET_PC.
- i_mem_read = (state==RUN), combinational. i_mem_read_address = PC, combinational.
- IDLE: start=1 -> PC<=program_address with low 2 bits cleared, state<=RUN, issue_valid<=0. Otherwise hold everything; redirects and stall are ignored.
- RUN, accept = i_mem_ready & ~stall & ~trap_valid & ~branch_valid.
- Redirect (trap_valid or branch_valid): PC<=target (trap wins) with low 2 bits cleared, and issue_valid<=0 (the in-flight request is squashed). The redirect applies even when stall=1 or i_mem_ready=0, and has 1-cycle latency to i_mem_read_address.
- Else if accept: issue_PC<=PC, issue_valid<=1, PC<=PC+4.
- Else if stall: PC, issue_PC and issue_valid hold.
- Else (i_mem_ready=0): PC holds, issue_PC holds, issue_valid<=0 (bubble).
- PC+4 wraps modulo 2^ADDRESS_BITS; there is no overflow flag.
- halt=1 in RUN: state<=IDLE, PC holds, issue_valid<=0. halt has priority over redirect and accept in the same cycle.
- A later start in IDLE reloads from program_address, not from the held PC.
- start is ignored in RUN.
- reset asserted mid-operation: immediate return to reset values, with no partial update.

Test Plan:
- Reset, then start=1 with program_address=0x100 and i_mem_ready=1 -> next cycle i_mem_read=1, address 0x100. Following cycles: addresses 0x104, 0x108; issue_PC lags by one cycle (0x100, 0x104); issue_valid=1.
- i_mem_ready=0 for 2 cycles at PC=0x108 -> address holds 0x108 and issue_valid=0 for both cycles. On ready, issue_PC=0x108 with issue_valid=1.
- stall=1 at PC=0x10C -> PC, issue_PC (0x108) and issue_valid=1 all held. stall=0 -> resumes at 0x10C.
- branch_valid with target 0x200, then simultaneous trap_valid (target 0x80) and branch_valid (target 0x300) -> address 0x200 with issue_valid=0, then 0x80 with issue_valid=0. Target 0x203 -> address 0x200.
- PC=0xFFFFFFFC accepted -> next address 0x00000000.
- halt in RUN -> i_mem_read=0 next cycle and PC held. reset low mid-run -> outputs at reset values asynchronously, address=RESET_PC.
